// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, 32x32 register file with write-through
// bypass, decoder, immediate sign-extension, branch resolution and the ID/EX register.
module id_stage #(
    parameter logic [3:0] NOP_CMD = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        branch_taken,
    output logic [31:0] branch_address,
    output logic [3:0]  ex_cmd,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_wb_en,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_val1,
    output logic [31:0] ex_val2,
    output logic [31:0] ex_st_val,
    output logic [31:0] ex_pc
);
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    logic [31:0] ir, ir_pc;
    logic [31:0] regs [32];
    logic [5:0]  op;
    logic [4:0]  src1, rt, rd;
    logic [31:0] imm_ext;
    logic [31:0] rv1, rv2;
    logic [3:0]  d_cmd;
    logic        d_wb, d_mr, d_mw, is_r;
    logic [4:0]  d_dest;
    logic [31:0] d_val2;

    assign op      = ir[31:26];
    assign src1    = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign imm_ext = {{16{ir[15]}}, ir[15:0]};

    // A taken branch squashes the instruction fetched alongside it.
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            ir    <= '0;
            ir_pc <= '0;
        end else begin
            ir    <= if_instruction;
            ir_pc <= if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_dest != 5'd0) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Write-through bypass lets write-back feed the instruction decoding in the same cycle.
    always_comb begin
        rv1 = regs[src1];
        if (src1 == 5'd0) rv1 = '0;
        else if (wb_en && wb_dest == src1) rv1 = wb_data;
        rv2 = regs[rt];
        if (rt == 5'd0) rv2 = '0;
        else if (wb_en && wb_dest == rt) rv2 = wb_data;
    end

    always_comb begin
        branch_taken = 1'b0;
        case (op)
            OP_BEZ:  branch_taken = (rv1 == 32'd0);
            OP_BNE:  branch_taken = (rv1 != rv2);
            OP_JMP:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    assign branch_address = ir_pc + 32'd4 + {imm_ext[29:0], 2'b00};

    always_comb begin
        d_cmd  = NOP_CMD;
        d_wb   = 1'b0;
        d_mr   = 1'b0;
        d_mw   = 1'b0;
        d_dest = '0;
        d_val2 = rv2;
        is_r   = 1'b1;
        case (op)
            OP_ADD:  d_cmd = 4'h0;
            OP_SUB:  d_cmd = 4'h2;
            OP_AND:  d_cmd = 4'h4;
            OP_OR:   d_cmd = 4'h5;
            OP_NOR:  d_cmd = 4'h6;
            OP_XOR:  d_cmd = 4'h7;
            OP_SLA:  d_cmd = 4'h8;
            OP_SLL:  d_cmd = 4'h9;
            OP_SRA:  d_cmd = 4'hA;
            OP_SRL:  d_cmd = 4'hB;
            default: is_r  = 1'b0;
        endcase
        if (is_r) begin
            d_wb   = 1'b1;
            d_dest = rd;
        end
        // Branches and unknown opcodes fall through as bubbles with NOP_CMD.
        case (op)
            OP_ADDI: begin d_cmd = 4'h0; d_val2 = imm_ext; d_dest = rt; d_wb = 1'b1; end
            OP_SUBI: begin d_cmd = 4'h2; d_val2 = imm_ext; d_dest = rt; d_wb = 1'b1; end
            OP_LD:   begin d_cmd = 4'h0; d_val2 = imm_ext; d_dest = rt; d_wb = 1'b1; d_mr = 1'b1; end
            OP_ST:   begin d_cmd = 4'h0; d_val2 = imm_ext; d_mw = 1'b1; end
            default: begin end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_cmd       <= NOP_CMD;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_wb_en     <= 1'b0;
            ex_dest      <= '0;
            ex_val1      <= '0;
            ex_val2      <= '0;
            ex_st_val    <= '0;
            ex_pc        <= '0;
        end else begin
            ex_cmd       <= d_cmd;
            ex_mem_read  <= d_mr;
            ex_mem_write <= d_mw;
            ex_wb_en     <= d_wb;
            ex_dest      <= d_dest;
            ex_val1      <= rv1;
            ex_val2      <= d_val2;
            ex_st_val    <= rv2;
            ex_pc        <= ir_pc;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table for the documented scenarios, then
// randomized traffic checked against an instruction-level reference model.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instruction, if_pc;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  ex_cmd;
    logic        ex_mem_read, ex_mem_write, ex_wb_en;
    logic [4:0]  ex_dest;
    logic [31:0] ex_val1, ex_val2, ex_st_val, ex_pc;

    int checks = 0;
    int failures = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .if_instruction(if_instruction), .if_pc(if_pc),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .branch_taken(branch_taken), .branch_address(branch_address),
        .ex_cmd(ex_cmd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_val1(ex_val1), .ex_val2(ex_val2),
        .ex_st_val(ex_st_val), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD = 6'b000001, ADDI = 6'b100000, SUBI = 6'b100001;
    localparam logic [5:0] LD = 6'b100100, ST = 6'b100101;
    localparam logic [5:0] BEZ = 6'b101000, BNE = 6'b101001, JMP = 6'b101010;
    localparam logic [5:0] R_OPS [10] = '{6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};
    localparam logic [3:0] R_CMDS [10] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

    typedef struct packed {
        logic        rst;
        logic [31:0] instr, pc;
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        c_br, bt;
        logic [31:0] ba;
        logic        c_ctl;
        logic [3:0]  cmd;
        logic        wbe, mr, mw;
        logic        c_dest;
        logic [4:0]  dest;
        logic        c_val;
        logic [31:0] v1, v2;
        logic        c_st;
        logic [31:0] st;
    } vec_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic        wbe, mr, mw;
        logic [4:0]  dest;
        logic [31:0] v1, v2, st, pc;
        logic        has_dest, has_val, has_st;
    } exp_t;

    vec_t vecs[$];

    logic [31:0] m_regs [32];
    logic [31:0] m_ir, m_pc;

    function automatic logic [31:0] ri(logic [5:0] op, logic [4:0] rd, logic [4:0] s1, logic [4:0] rt);
        return {op, s1, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] ii(logic [5:0] op, logic [4:0] rt, logic [4:0] s1, logic [15:0] imm);
        return {op, s1, rt, imm};
    endfunction

    function automatic vec_t row(logic r, logic [31:0] ins, logic [31:0] pc, logic we, logic [4:0] wd, logic [31:0] wdat);
        vec_t v = '0;
        v.rst = r; v.instr = ins; v.pc = pc; v.we = we; v.wd = wd; v.wdat = wdat;
        return v;
    endfunction

    function automatic vec_t w_br(vec_t v, logic bt, logic [31:0] ba);
        v.c_br = 1'b1; v.bt = bt; v.ba = ba;
        return v;
    endfunction

    function automatic vec_t w_ctl(vec_t v, logic [3:0] cmd, logic wbe, logic mr, logic mw);
        v.c_ctl = 1'b1; v.cmd = cmd; v.wbe = wbe; v.mr = mr; v.mw = mw;
        return v;
    endfunction

    function automatic vec_t w_val(vec_t v, logic use_dest, logic [4:0] dest, logic [31:0] v1, logic [31:0] v2);
        v.c_dest = use_dest; v.dest = dest; v.c_val = 1'b1; v.v1 = v1; v.v2 = v2;
        return v;
    endfunction

    function automatic vec_t w_st(vec_t v, logic [31:0] st);
        v.c_st = 1'b1; v.st = st;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        rst = v.rst; if_instruction = v.instr; if_pc = v.pc;
        wb_en = v.we; wb_dest = v.wd; wb_data = v.wdat;
        #1;
        if (v.c_br) begin
            checkOutput("branch_taken", {31'd0, branch_taken}, {31'd0, v.bt});
            checkOutput("branch_address", branch_address, v.ba);
        end
        @(posedge clk);
        #1;
        if (v.c_ctl) begin
            checkOutput("ex_cmd", {28'd0, ex_cmd}, {28'd0, v.cmd});
            checkOutput("ex_ctl", {29'd0, ex_wb_en, ex_mem_read, ex_mem_write}, {29'd0, v.wbe, v.mr, v.mw});
        end
        if (v.c_dest) checkOutput("ex_dest", {27'd0, ex_dest}, {27'd0, v.dest});
        if (v.c_val) begin
            checkOutput("ex_val1", ex_val1, v.v1);
            checkOutput("ex_val2", ex_val2, v.v2);
        end
        if (v.c_st) checkOutput("ex_st_val", ex_st_val, v.st);
    endtask

    // Reference model: register reads see the value write-back is presenting this cycle.
    function automatic logic [31:0] model_read(logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_dest == idx) return wb_data;
        return m_regs[idx];
    endfunction

    function automatic exp_t model_decode(logic [31:0] ins, logic [31:0] pc);
        exp_t e = '0;
        logic [5:0]  op = ins[31:26];
        logic [4:0]  s1 = ins[25:21];
        logic [4:0]  rt = ins[20:16];
        logic [31:0] imm = {{16{ins[15]}}, ins[15:0]};
        e.cmd = 4'hF;
        e.pc = pc;
        for (int i = 0; i < 10; i++) begin
            if (op == R_OPS[i]) begin
                e.cmd = R_CMDS[i]; e.wbe = 1'b1; e.dest = ins[15:11];
                e.v1 = model_read(s1); e.v2 = model_read(rt);
                e.has_dest = 1'b1; e.has_val = 1'b1;
            end
        end
        if (op == ADDI || op == SUBI || op == LD || op == ST) begin
            e.cmd = (op == SUBI) ? 4'h2 : 4'h0;
            e.v1 = model_read(s1); e.v2 = imm; e.has_val = 1'b1;
            e.mr = (op == LD);
            e.mw = (op == ST);
            e.wbe = (op != ST);
            e.dest = rt; e.has_dest = (op != ST);
            e.st = model_read(rt); e.has_st = (op == ST);
        end
        return e;
    endfunction

    task automatic randStep();
        logic [31:0] tmp, ins, pc, ba;
        logic [5:0]  op;
        logic        r, bt;
        int          k;
        exp_t        e;
        r = ($urandom_range(0, 29) == 0);
        k = $urandom_range(0, 18);
        tmp = $urandom;
        if (k < 10) op = R_OPS[k];
        else if (k == 10) op = ADDI;
        else if (k == 11) op = SUBI;
        else if (k == 12) op = LD;
        else if (k == 13) op = ST;
        else if (k == 14) op = BEZ;
        else if (k == 15) op = BNE;
        else if (k == 16) op = JMP;
        else if (k == 17) op = 6'd0;
        else op = tmp[31:26];
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), tmp[15:0]};
        tmp = $urandom;
        pc = {tmp[31:2], 2'b00};
        rst = r; if_instruction = ins; if_pc = pc;
        wb_en = ($urandom_range(0, 1) == 1);
        wb_dest = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 3);
        wb_data = (k == 3) ? $urandom : 32'(k);
        #1;
        op = m_ir[31:26];
        bt = (op == JMP) || (op == BEZ && model_read(m_ir[25:21]) == 32'd0) ||
             (op == BNE && model_read(m_ir[25:21]) != model_read(m_ir[20:16]));
        ba = m_pc + 32'd4 + 32'($signed(m_ir[15:0]) * 4);
        checkOutput("rand branch_taken", {31'd0, branch_taken}, {31'd0, bt});
        checkOutput("rand branch_address", branch_address, ba);
        if (r) begin
            e = '0; e.cmd = 4'hF; e.has_dest = 1'b1; e.has_val = 1'b1; e.has_st = 1'b1;
        end else begin
            e = model_decode(m_ir, m_pc);
        end
        if (r) for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        else if (wb_en && wb_dest != 5'd0) m_regs[wb_dest] = wb_data;
        m_ir = (r || bt) ? 32'd0 : ins;
        m_pc = (r || bt) ? 32'd0 : pc;
        @(posedge clk);
        #1;
        checkOutput("rand ex_cmd", {28'd0, ex_cmd}, {28'd0, e.cmd});
        checkOutput("rand ex_ctl", {29'd0, ex_wb_en, ex_mem_read, ex_mem_write}, {29'd0, e.wbe, e.mr, e.mw});
        if (e.has_dest) checkOutput("rand ex_dest", {27'd0, ex_dest}, {27'd0, e.dest});
        if (e.has_val) begin
            checkOutput("rand ex_val1", ex_val1, e.v1);
            checkOutput("rand ex_val2", ex_val2, e.v2);
            checkOutput("rand ex_pc", ex_pc, e.pc);
        end
        if (e.has_st) checkOutput("rand ex_st_val", ex_st_val, e.st);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; if_instruction = '0; if_pc = '0; wb_en = 1'b0; wb_dest = '0; wb_data = '0;

        vecs.push_back(row(1, 0, 0, 0, 0, 0));
        v = w_st(w_val(w_ctl(w_br(row(1, 0, 0, 0, 0, 0), 0, 32'h4), 4'hF, 0, 0, 0), 1, 0, 0, 0), 0);
        vecs.push_back(v);
        vecs.push_back(w_ctl(w_br(row(0, 32'h8001060A, 32'h100, 1, 1, 32'd1024), 0, 32'h4), 4'hF, 0, 0, 0));
        vecs.push_back(w_val(w_ctl(row(0, 0, 32'h104, 1, 2, 32'd7), 4'h0, 1, 0, 0), 1, 1, 0, 32'd1546));
        vecs.push_back(w_ctl(row(0, ii(ST, 2, 1, 16'd20), 32'h108, 1, 3, 32'd3), 4'hF, 0, 0, 0));
        v = w_st(w_val(w_ctl(row(0, ii(LD, 5, 1, 16'hFFFC), 32'h10C, 0, 0, 0), 4'h0, 0, 0, 1), 0, 0, 32'd1024, 32'd20), 32'd7);
        vecs.push_back(v);
        vecs.push_back(w_val(w_ctl(row(0, ri(ADD, 3, 2, 0), 32'h110, 0, 0, 0), 4'h0, 1, 1, 0), 1, 5, 32'd1024, 32'hFFFFFFFC));
        vecs.push_back(w_val(w_ctl(row(0, 0, 32'h114, 1, 2, 32'h60A), 4'h0, 1, 0, 0), 1, 3, 32'h60A, 0));
        vecs.push_back(w_ctl(row(0, ri(ADD, 4, 0, 0), 32'h118, 1, 0, 32'd5), 4'hF, 0, 0, 0));
        vecs.push_back(w_val(w_ctl(row(0, 0, 32'h11C, 1, 0, 32'd5), 4'h0, 1, 0, 0), 1, 4, 0, 0));
        vecs.push_back(row(0, 0, 0, 1, 1, 32'd3));
        vecs.push_back(row(0, 0, 0, 1, 3, 32'd2));
        vecs.push_back(row(0, ii(BNE, 3, 1, 16'hFFE4), 32'h130, 0, 0, 0));
        vecs.push_back(w_br(row(0, ii(ADDI, 7, 0, 16'd99), 32'h134, 0, 0, 0), 1, 32'hC4));
        vecs.push_back(w_ctl(w_br(row(0, ii(ADDI, 8, 0, 16'd5), 32'hC4, 0, 0, 0), 0, 32'h4), 4'hF, 0, 0, 0));
        vecs.push_back(w_val(w_ctl(row(0, 0, 32'hC8, 1, 3, 32'd3), 4'h0, 1, 0, 0), 1, 8, 0, 32'd5));
        vecs.push_back(row(0, ii(BNE, 3, 1, 16'hFFE4), 32'h130, 0, 0, 0));
        vecs.push_back(w_br(row(0, 0, 32'h134, 0, 0, 0), 0, 32'hC4));
        vecs.push_back(row(0, ii(BEZ, 0, 9, 16'h0010), 32'h200, 0, 0, 0));
        vecs.push_back(w_br(row(0, 0, 32'h204, 0, 0, 0), 1, 32'h244));
        vecs.push_back(w_br(row(0, ii(JMP, 0, 0, 16'hFFFF), 32'h180, 0, 0, 0), 0, 32'h4));
        vecs.push_back(w_br(row(0, ii(JMP, 0, 0, 16'hFFFF), 32'h180, 0, 0, 0), 1, 32'h180));
        vecs.push_back(w_ctl(w_br(row(0, ii(JMP, 0, 0, 16'hFFFF), 32'h180, 0, 0, 0), 0, 32'h4), 4'hF, 0, 0, 0));
        v = w_val(w_ctl(w_br(row(1, ii(JMP, 0, 0, 16'hFFFF), 32'h180, 1, 10, 32'd77), 1, 32'h180), 4'hF, 0, 0, 0), 1, 0, 0, 0);
        vecs.push_back(v);
        vecs.push_back(w_br(row(0, ri(ADD, 11, 10, 0), 32'h300, 0, 0, 0), 0, 32'h4));
        vecs.push_back(w_val(w_ctl(row(0, 0, 32'h304, 0, 0, 0), 4'h0, 1, 0, 0), 1, 11, 0, 0));

        @(posedge clk);
        #1;
        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        m_ir = '0;
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        applyStimulus(row(1, 0, 0, 0, 0, 0));
        applyStimulus(row(1, 0, 0, 0, 0, 0));
        $display("[TB] randomized phase");
        for (int i = 0; i < 600; i++) randStep();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage, directly downstream of the instruction-fetch stage.
- Contains the IF/ID pipeline register, the 32x32 register file with a write-back port, the decoder, the immediate sign-extender and the branch resolver.
- Drives `branch_taken` and `branch_address` back to fetch.
- Produces a registered ID/EX bundle for the execute stage.

Parameters:
- NOP_CMD, 4'hF, execute command emitted for bubbles, NOP and unknown opcodes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_instruction  in  32  instruction from fetch.
- if_pc  in  32  address of `if_instruction`.
- wb_en  in  1  register-file write enable from write-back.
- wb_dest  in  5  write-back register index.
- wb_data  in  32  write-back value.
- branch_taken  out  1  combinational; redirect fetch.
- branch_address  out  32  combinational redirect target.
- ex_cmd  out  4  registered ALU command.
- ex_mem_read  out  1  registered; LD.
- ex_mem_write  out  1  registered; ST.
- ex_wb_en  out  1  registered; result is written back.
- ex_dest  out  5  registered destination index.
- ex_val1  out  32  registered operand 1 = R[src1].
- ex_val2  out  32  registered operand 2 = R[src2] or sign-extended imm.
- ex_st_val  out  32  registered store data.
- ex_pc  out  32  registered instruction address.

Behaviour:
- Fields of the IF/ID instruction `ir`:
  - op = ir[31:26]
  - src1 = ir[25:21]
  - rt = ir[20:16]
  - rd = ir[15:11]
  - imm = ir[15:0], sign-extended to 32 bits.
- IF/ID register (`ir`, `ir_pc`): loads `if_instruction`/`if_pc` every posedge. Loads ir = 0 (NOP) and ir_pc = 0 when rst or `branch_taken`.
- Opcode map and decode:
  - R-type: src2 = rt, dest = rd, wb = 1. Commands: ADD 000001→cmd 0, SUB 000011→2, AND 000101→4, OR 000110→5, NOR 000111→6, XOR 001000→7, SLA 001001→8, SLL 001010→9, SRA 001011→A, SRL 001100→B.
  - ADDI 100000: cmd 0, val2 = imm, dest = rt, wb = 1.
  - SUBI 100001: cmd 2, val2 = imm, dest = rt, wb = 1.
  - LD 100100: cmd 0, val2 = imm, dest = rt, mem_read = 1, wb = 1.
  - ST 100101: cmd 0, val2 = imm, st_val = R[rt], mem_write = 1, wb = 0.
  - BEZ 101000, BNE 101001, JMP 101010: cmd = NOP_CMD, wb = mem_read = mem_write = 0.
  - 000000 and any other opcode: NOP, all controls 0, cmd = NOP_CMD.
- Branches:
  - BEZ taken iff R[src1] == 0.
  - BNE taken iff R[src1] != R[rt].
  - JMP always taken.
  - branch_address = ir_pc + 4 + (sext(imm) << 2), 32-bit wrap-around. Example: imm = -1 targets the branch itself.
  - `branch_taken` is combinational from `ir` and the register file.
  - One-cycle penalty: the instruction fetched alongside a taken branch is squashed by the IF/ID flush.
  - A taken branch is never asserted two cycles in a row, because the flushed slot is a NOP.
- Register file:
  - 32 x 32-bit, write at posedge when wb_en && wb_dest != 0.
  - R0 reads 0 always; writes to R0 are ignored.
  - Reads are combinational with write-through bypass: if wb_en && wb_dest == index != 0, the read returns `wb_data` in the same cycle.
  - rst clears all entries.
- ID/EX register:
  - Captures the decoded bundle each posedge.
  - rst clears all outputs to 0 except ex_cmd = NOP_CMD.
  - A branch in ID produces a bubble (all controls 0).
- Latency: instruction presented on `if_instruction` at edge n appears on the ex_* outputs after edge n+1.
- No hazard detection or forwarding: software inserts NOPs. Only write-back-to-decode is covered, by the bypass.
- rst asserted mid-stream wins over the branch flush and over write-back in the same edge.
- `branch_taken` is 0 during the cycle after reset, since ir = 0.

Test Plan:
- Reset: hold rst 2 cycles → branch_taken = 0, ex_cmd = F, ex_wb_en = 0, ex_val1 = 0; any register read returns 0.
- ADDI: if_instruction = 0x8001060A (ADDI r1, r0, 1546) at edge 0 → after edge 1: ex_cmd = 0, ex_dest = 1, ex_val1 = 0, ex_val2 = 1546, ex_wb_en = 1.
- Bypass: wb_en = 1, wb_dest = 2, wb_data = 0x60A while ID holds ADD r3, r2, r0 → ex_val1 = 0x60A at the next edge. A write to r0 with wb_data = 5 → later reads of r0 = 0.
- LD/ST: ST r2, r1, 20 with R1 = 1024, R2 = 7 → ex_mem_write = 1, ex_val1 = 1024, ex_val2 = 20, ex_st_val = 7, ex_wb_en = 0. LD r5, r1, -4 → ex_val2 = 0xFFFFFFFC, ex_dest = 5, ex_mem_read = 1.
- Branches:
  - BNE r1, r3, -28 at ir_pc = 0x130 with R1 = 3, R3 = 2 → branch_taken = 1, branch_address = 0xC4; the next IF/ID content is NOP.
  - Same instruction with R3 = 3 → branch_taken = 0.
  - BEZ with R[src1] = 0 → taken.
- JMP -1 at 0x180 → branch_address = 0x180, taken. The following cycle is NOP (branch_taken = 0). The pattern alternates while fetch re-presents the JMP.
